joystick_poll_ctrl: RTL and testbench

- Scheduler that shares one 40-bit SPI transfer engine between two joystick modules, one per Pong player.
- On every poll tick it runs one full transaction to player 1, then one to player 2.
- It drives the LED command byte, decodes each 5-byte response into 10-bit X/Y positions and 3 button bits, and holds the results for the paddle logic.
- It sits between the top level and the SPI engine, which owns cs/mosi/miso/sck and selects the device from dev_sel.

---
 rtl/joystick_poll_ctrl.sv | 171 +++++++++++++++++
 tb/tb_joystick_poll_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/joystick_poll_ctrl.sv
// joystick_poll_ctrl: time-shares one 40-bit SPI engine between two joysticks.
// On each poll tick it runs player 1 and then player 2, and decodes X/Y/buttons.
// Ports:
//   clk50M, rst          : clock, synchronous active-high reset
//   enable               : allows new poll sequences
//   led_p1, led_p2       : LED bits sent in each player's command byte
//   spi_start/spi_tx     : launch pulse and outgoing 40-bit frame
//   dev_sel              : 0 = joystick 1, 1 = joystick 2
//   spi_done/spi_rx      : completion pulse and received frame
//   pN_x/pN_y/pN_btn     : decoded positions and buttons per player
//   pN_valid             : one-cycle pulse when that player's data updates
//   pN_err               : last transaction to that player timed out
module joystick_poll_ctrl #(
    parameter int POLL_CYCLES    = 50000,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        clk50M,
    input  logic        rst,
    input  logic        enable,
    input  logic [1:0]  led_p1,
    input  logic [1:0]  led_p2,
    output logic        spi_start,
    output logic [39:0] spi_tx,
    output logic        dev_sel,
    input  logic        spi_done,
    input  logic [39:0] spi_rx,
    output logic [9:0]  p1_x,
    output logic [9:0]  p1_y,
    output logic [2:0]  p1_btn,
    output logic [9:0]  p2_x,
    output logic [9:0]  p2_y,
    output logic [2:0]  p2_btn,
    output logic        p1_valid,
    output logic        p2_valid,
    output logic        p1_err,
    output logic        p2_err
);

    localparam int PW = $clog2(POLL_CYCLES);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT,
        CAPTURE,
        NEXT
    } state_t;

    state_t        state;
    logic [PW-1:0] poll_cnt;
    logic [TW-1:0] tmo_cnt;
    logic          pending;
    logic          tick;
    logic [39:0]   rx_q;
    logic [1:0]    led_sel;

    assign tick    = enable && (poll_cnt == POLL_LAST);
    assign led_sel = dev_sel ? led_p2 : led_p1;

    // Free-running poll period; parked at zero while polling is disabled.
    always_ff @(posedge clk50M) begin
        if (rst) begin
            poll_cnt <= '0;
        end else if (!enable || poll_cnt == POLL_LAST) begin
            poll_cnt <= '0;
        end else begin
            poll_cnt <= poll_cnt + PW'(1);
        end
    end

    always_ff @(posedge clk50M) begin
        if (rst) begin
            state     <= IDLE;
            pending   <= 1'b0;
            tmo_cnt   <= '0;
            rx_q      <= '0;
            spi_start <= 1'b0;
            spi_tx    <= '0;
            dev_sel   <= 1'b0;
            p1_x      <= '0;
            p1_y      <= '0;
            p1_btn    <= '0;
            p2_x      <= '0;
            p2_y      <= '0;
            p2_btn    <= '0;
            p1_valid  <= 1'b0;
            p2_valid  <= 1'b0;
            p1_err    <= 1'b0;
            p2_err    <= 1'b0;
        end else begin
            spi_start <= 1'b0;
            p1_valid  <= 1'b0;
            p2_valid  <= 1'b0;

            // Only one missed tick is remembered; extra ones are dropped.
            if (tick && state != IDLE) begin
                pending <= 1'b1;
            end

            unique case (state)
                IDLE: begin
                    if (tick || (pending && enable)) begin
                        pending <= 1'b0;
                        dev_sel <= 1'b0;
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    // Start pulse is registered here so it is high
                    // for exactly the START cycle.
                    spi_tx    <= {6'b100000, led_sel, 32'h0};
                    spi_start <= 1'b1;
                    state     <= START;
                end
                START: begin
                    tmo_cnt <= '0;
                    state   <= WAIT;
                end
                WAIT: begin
                    // Done is checked first so it wins over expiry.
                    if (spi_done) begin
                        rx_q  <= spi_rx;
                        state <= CAPTURE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        if (dev_sel) begin
                            p2_err <= 1'b1;
                        end else begin
                            p1_err <= 1'b1;
                        end
                        state <= NEXT;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                CAPTURE: begin
                    if (dev_sel) begin
                        p2_x     <= {rx_q[25:24], rx_q[39:32]};
                        p2_y     <= {rx_q[9:8], rx_q[23:16]};
                        p2_btn   <= rx_q[2:0];
                        p2_err   <= 1'b0;
                        p2_valid <= 1'b1;
                    end else begin
                        p1_x     <= {rx_q[25:24], rx_q[39:32]};
                        p1_y     <= {rx_q[9:8], rx_q[23:16]};
                        p1_btn   <= rx_q[2:0];
                        p1_err   <= 1'b0;
                        p1_valid <= 1'b1;
                    end
                    state <= NEXT;
                end
                NEXT: begin
                    if (!dev_sel) begin
                        dev_sel <= 1'b1;
                        state   <= LOAD;
                    end else begin
                        dev_sel <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_joystick_poll_ctrl.sv
// tb_joystick_poll_ctrl: scoreboard bench for joystick_poll_ctrl.
// Stimulus queues expected starts/results; a monitor pops and compares them.
module tb_joystick_poll_ctrl;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [1:0]  led_p1;
    logic [1:0]  led_p2;
    logic        spi_start;
    logic [39:0] spi_tx;
    logic        dev_sel;
    logic        spi_done;
    logic [39:0] spi_rx;
    logic [9:0]  p1_x, p1_y, p2_x, p2_y;
    logic [2:0]  p1_btn, p2_btn;
    logic        p1_valid, p2_valid, p1_err, p2_err;

    joystick_poll_ctrl #(
        .POLL_CYCLES   (8),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk50M   (clk),
        .rst      (rst),
        .enable   (enable),
        .led_p1   (led_p1),
        .led_p2   (led_p2),
        .spi_start(spi_start),
        .spi_tx   (spi_tx),
        .dev_sel  (dev_sel),
        .spi_done (spi_done),
        .spi_rx   (spi_rx),
        .p1_x     (p1_x),
        .p1_y     (p1_y),
        .p1_btn   (p1_btn),
        .p2_x     (p2_x),
        .p2_y     (p2_y),
        .p2_btn   (p2_btn),
        .p1_valid (p1_valid),
        .p2_valid (p2_valid),
        .p1_err   (p1_err),
        .p2_err   (p2_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        dev;
        logic [39:0] tx;
    } start_t;

    typedef struct packed {
        logic        pl;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [2:0]  btn;
    } res_t;

    start_t sq[$];
    res_t   rq[$];

    int n_checks = 0;
    int n_errors = 0;
    int n_starts = 0;

    logic        eng_en  [2];
    int          eng_dly [2];
    logic [39:0] eng_rx  [2];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // SPI engine model: answers dev_sel's request after eng_dly cycles.
    initial begin
        int d;
        spi_done = 1'b0;
        spi_rx   = '0;
        forever begin
            @(negedge clk);
            if (spi_start && !rst) begin
                d = dev_sel ? 1 : 0;
                if (eng_en[d]) begin
                    repeat (eng_dly[d]) @(negedge clk);
                    spi_done = 1'b1;
                    spi_rx   = eng_rx[d];
                    @(negedge clk);
                    spi_done = 1'b0;
                    spi_rx   = '0;
                end
            end
        end
    end

    // Monitor: compares every presented output against the queues.
    initial begin
        start_t e;
        res_t   r;
        logic   v1_d, v2_d;
        v1_d = 1'b0;
        v2_d = 1'b0;
        forever begin
            @(negedge clk);
            if (spi_start) begin
                n_starts++;
                if (sq.size() == 0) begin
                    chk("start_unexpected", spi_start, 0);
                end else begin
                    e = sq.pop_front();
                    chk("start_dev_sel", dev_sel, e.dev);
                    chk("start_spi_tx", spi_tx, e.tx);
                end
            end
            if (p1_valid) begin
                chk("p1_valid_width", v1_d, 0);
                if (rq.size() == 0) begin
                    chk("p1_valid_unexpected", p1_valid, 0);
                end else begin
                    r = rq.pop_front();
                    chk("p1_valid_player", 0, r.pl);
                    chk("p1_x", p1_x, r.x);
                    chk("p1_y", p1_y, r.y);
                    chk("p1_btn", p1_btn, r.btn);
                end
            end
            if (p2_valid) begin
                chk("p2_valid_width", v2_d, 0);
                if (rq.size() == 0) begin
                    chk("p2_valid_unexpected", p2_valid, 0);
                end else begin
                    r = rq.pop_front();
                    chk("p2_valid_player", 1, r.pl);
                    chk("p2_x", p2_x, r.x);
                    chk("p2_y", p2_y, r.y);
                    chk("p2_btn", p2_btn, r.btn);
                end
            end
            v1_d = p1_valid;
            v2_d = p2_valid;
        end
    end

    task automatic push_start(input logic dev, input logic [39:0] tx);
        start_t e;
        e.dev = dev;
        e.tx  = tx;
        sq.push_back(e);
    endtask

    task automatic push_res(input logic pl, input logic [9:0] x,
                            input logic [9:0] y, input logic [2:0] btn);
        res_t r;
        r.pl  = pl;
        r.x   = x;
        r.y   = y;
        r.btn = btn;
        rq.push_back(r);
    endtask

    task automatic wait_start(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (spi_start !== 1'b1 && n < 200);
        if (spi_start !== 1'b1) chk("start_timeout", spi_start, 1);
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_spi_start"}, spi_start, 0);
        chk({nm, "_spi_tx"}, spi_tx, 0);
        chk({nm, "_dev_sel"}, dev_sel, 0);
        chk({nm, "_p1_data"}, {p1_x, p1_y, p1_btn}, 0);
        chk({nm, "_p2_data"}, {p2_x, p2_y, p2_btn}, 0);
        chk({nm, "_flags"}, {p1_valid, p2_valid, p1_err, p2_err}, 0);
    endtask

    task automatic run_poll();
        int n;
        enable = 1'b1;
        wait_start(n);
        enable = 1'b0;
    endtask

    initial begin
        int n, m, base;
        rst    = 1'b1;
        enable = 1'b0;
        led_p1 = 2'b11;
        led_p2 = 2'b01;
        eng_en[0] = 1'b1; eng_dly[0] = 3;  eng_rx[0] = 40'h2A_03_55_01_05;
        eng_en[1] = 1'b0; eng_dly[1] = 1;  eng_rx[1] = '0;
        repeat (3) @(negedge clk);

        // Basic poll: p1 answers, p2 times out.
        push_start(0, 40'h83_0000_0000);
        push_res(0, 10'h32A, 10'h155, 3'b101);
        push_start(1, 40'h81_0000_0000);
        enable = 1'b1;
        rst    = 1'b0;
        check_zero("reset");
        wait_start(n);
        enable = 1'b0;
        chk("first_start_cycle", 1 + n, 10);
        m = 0;
        do begin @(negedge clk); m++; end while (!p1_valid && m < 40);
        chk("p1_valid_latency", m, 5);
        wait_start(n);
        chk("p2_start_gap", n, 2);
        m = 0;
        do begin @(negedge clk); m++; end while (!p2_err && m < 60);
        chk("p2_err_latency", m, 17);
        chk("p2_err_set", p2_err, 1);
        chk("p2_data_hold", {p2_x, p2_y, p2_btn}, 0);
        chk("p1_err_clear", p1_err, 0);
        repeat (10) @(negedge clk);
        chk("p1_x_hold", p1_x, 10'h32A);

        // p2 answers in the same cycle the timeout expires.
        led_p1 = 2'b10;
        led_p2 = 2'b11;
        eng_rx[0] = 40'h7F_02_C3_03_06;
        eng_en[1] = 1'b1; eng_dly[1] = 16; eng_rx[1] = 40'h10_FD_20_FC_0B;
        push_start(0, 40'h82_0000_0000);
        push_res(0, 10'h27F, 10'h3C3, 3'b110);
        push_start(1, 40'h83_0000_0000);
        push_res(1, 10'h110, 10'h020, 3'b011);
        run_poll();
        repeat (60) @(negedge clk);
        chk("p2_err_cleared", p2_err, 0);
        chk("p2_x_same_cycle", p2_x, 10'h110);

        // p1 answers one cycle too late: timeout, data held.
        led_p1 = 2'b00;
        led_p2 = 2'b10;
        eng_dly[0] = 17;
        eng_dly[1] = 2;  eng_rx[1] = 40'h01_00_02_01_07;
        push_start(0, 40'h80_0000_0000);
        push_start(1, 40'h82_0000_0000);
        push_res(1, 10'h001, 10'h102, 3'b111);
        run_poll();
        repeat (60) @(negedge clk);
        chk("p1_err_late", p1_err, 1);
        chk("p1_data_hold", {p1_x, p1_y, p1_btn}, {10'h27F, 10'h3C3, 3'b110});
        chk("p2_err_ok", p2_err, 0);

        // Reset, then ticks during long transfers leave one pending run.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_zero("reset2");
        led_p1 = 2'b01;
        led_p2 = 2'b00;
        eng_dly[0] = 15; eng_rx[0] = 40'h55_02_AA_01_01;
        eng_dly[1] = 15; eng_rx[1] = 40'hFF_03_FF_03_07;
        for (int k = 0; k < 2; k++) begin
            push_start(0, 40'h81_0000_0000);
            push_res(0, 10'h255, 10'h1AA, 3'b001);
            push_start(1, 40'h80_0000_0000);
            push_res(1, 10'h3FF, 10'h3FF, 3'b111);
        end
        base   = n_starts;
        enable = 1'b1;
        rst    = 1'b0;
        wait_start(n);
        repeat (30) @(negedge clk);
        enable = 1'b0;
        repeat (60) @(negedge clk);
        chk("pend_held_starts", n_starts - base, 2);
        chk("pend_held_p2", p2_x, 10'h3FF);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        repeat (80) @(negedge clk);
        chk("pend_replay_starts", n_starts - base, 4);
        chk("pend_queue_empty", sq.size(), 0);

        // Reset mid-WAIT, late spi_done must be ignored.
        eng_dly[0] = 10;
        push_start(0, 40'h81_0000_0000);
        run_poll();
        base = n_starts;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_zero("rst_wait");
        repeat (30) @(negedge clk);
        check_zero("late_done");

        // Polling disabled: no transfers at all.
        repeat (150) @(negedge clk);
        chk("disabled_starts", n_starts - base, 0);
        chk("final_start_q", sq.size(), 0);
        chk("final_res_q", rq.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
